yuv_line_streamer: RTL and testbench



---
 rtl/yuv_line_streamer_pkg.sv | 29 ++
 rtl/yuv_line_streamer_if.sv | 37 +++
 rtl/yuv_line_streamer_axis_sync_fifo.sv | 80 ++++++++
 rtl/yuv_line_streamer.sv | 212 +++++++++++++++++++++
 tb/tb_yuv_line_streamer.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yuv_line_streamer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : yuv_stream_pkg                                             |
// | Description : Shared types and constants for the YUV line streamer:      |
// |               sequencer state encoding, in-flight read tag and the       |
// |               width of the per-frame line counter.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package yuv_stream_pkg;

  // Width of the LINE_CNT output (lines streamed since the last VSYNC).
  localparam int c_LINE_CNT_W = 16;

  // Read sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Tag travelling alongside each outstanding buffer read.
  typedef struct packed {
    logic valid;  // a read was issued in this slot
    logic sof;    // word is the first beat of a frame
    logic eol;    // word is the last beat of a line
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/yuv_line_streamer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : yuv_line_streamer_if                                       |
// | Description : AXI4-Stream video bus carrying the streamed YUV422 words.  |
// |               TUSER = start of frame, TLAST = end of line.               |
// | Ports       : master drives TDATA/TVALID/TUSER/TLAST, samples TREADY;    |
// |               slave is the mirror image.                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface yuv_line_streamer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TVALID;
  logic                  TREADY;
  logic                  TUSER;
  logic                  TLAST;

  modport master (
    output TDATA,
    output TVALID,
    output TUSER,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    input  TUSER,
    input  TLAST,
    output TREADY
  );

endinterface
`default_nettype wire

// File: rtl/yuv_line_streamer_axis_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_sync_fifo                                             |
// | Description : First-word-fall-through FIFO over {tuser, tlast, tdata}.   |
// |               The head entry is visible on the outputs whenever the      |
// |               FIFO is not empty; outputs read as zero when empty.        |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               i_push + i_tdata/i_tuser/i_tlast : write side              |
// |               i_pop                            : consume head entry      |
// |               o_tdata/o_tuser/o_tlast          : head entry              |
// |               o_empty, o_count                 : occupancy               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         i_push,
  input  wire logic [DATA_WIDTH-1:0]        i_tdata,
  input  wire logic                         i_tuser,
  input  wire logic                         i_tlast,
  input  wire logic                         i_pop,
  output logic      [DATA_WIDTH-1:0]        o_tdata,
  output logic                              o_tuser,
  output logic                              o_tlast,
  output logic                              o_empty,
  output logic      [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(DEPTH+1);
  localparam int c_WORD_W = DATA_WIDTH + 2;

  logic [c_WORD_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_full;
  logic                w_do_push;
  logic                w_do_pop;
  logic [c_WORD_W-1:0] w_head;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == c_CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= {i_tuser, i_tlast, i_tdata};
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign o_tdata = o_empty ? '0   : w_head[DATA_WIDTH-1:0];
  assign o_tlast = o_empty ? 1'b0 : w_head[DATA_WIDTH];
  assign o_tuser = o_empty ? 1'b0 : w_head[DATA_WIDTH+1];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/yuv_line_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : yuv_line_streamer                                          |
// | Description : Read-side sequencer behind the camera line buffer. On each |
// |               qualified camera line it sweeps the buffer read address,   |
// |               captures the YUV422 words returned READ_LATENCY cycles     |
// |               later and emits them as an AXI4-Stream video line.         |
// | Ports       : CLK, RESETN (async, active-low)                            |
// |               VSYNC, HSYNC, RD_EN : asynchronous camera/buffer status    |
// |               ADDRB, DATA_IN      : line-buffer read port                |
// |               M_AXIS              : AXI4-Stream master                   |
// |               OVERRUN             : sticky, line arrived while busy      |
// |               LINE_CNT            : lines streamed since last VSYNC      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module yuv_line_streamer
  import yuv_stream_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int LINE_WORDS   = 320,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  wire logic                    CLK,
  input  wire logic                    RESETN,
  input  wire logic                    VSYNC,
  input  wire logic                    HSYNC,
  input  wire logic                    RD_EN,
  output logic      [ADDR_WIDTH-1:0]   ADDRB,
  input  wire logic [DATA_WIDTH-1:0]   DATA_IN,
  yuv_line_streamer_if.master          M_AXIS,
  output logic                         OVERRUN,
  output logic      [c_LINE_CNT_W-1:0] LINE_CNT
);

  localparam int                c_CNT_W     = $clog2(FIFO_DEPTH+1);
  localparam int                c_OCC_W     = $clog2(2*FIFO_DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(LINE_WORDS-1);

  // ---------------------------------------------------------------- sync
  logic [1:0] r_vs_sync;
  logic [1:0] r_hs_sync;
  logic [1:0] r_rd_sync;
  logic       r_vs_d;
  logic       r_hs_d;
  logic       w_vs_rise;
  logic       w_hs_rise;
  logic       w_rd_en_s;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_vs_sync <= '0;
      r_hs_sync <= '0;
      r_rd_sync <= '0;
      r_vs_d    <= 1'b0;
      r_hs_d    <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[0], VSYNC};
      r_hs_sync <= {r_hs_sync[0], HSYNC};
      r_rd_sync <= {r_rd_sync[0], RD_EN};
      r_vs_d    <= r_vs_sync[1];
      r_hs_d    <= r_hs_sync[1];
    end
  end

  assign w_vs_rise = r_vs_sync[1] & ~r_vs_d;
  assign w_hs_rise = r_hs_sync[1] & ~r_hs_d;
  assign w_rd_en_s = r_rd_sync[1];

  // ---------------------------------------------------------------- state
  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_sof_pending;
  logic                    r_overrun;
  logic [c_LINE_CNT_W-1:0] r_line_cnt;
  tag_t                    r_tag [READ_LATENCY];

  logic                    w_issue;
  logic                    w_line_done;
  logic                    w_credit;
  logic [c_OCC_W-1:0]      w_inflight;
  logic [c_OCC_W-1:0]      w_occupancy;

  logic [c_CNT_W-1:0]      w_fifo_count;
  logic                    w_fifo_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [DATA_WIDTH-1:0]   w_head_tdata;
  logic                    w_head_tuser;
  logic                    w_head_tlast;

  // Outstanding reads not yet in the FIFO.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      w_inflight = w_inflight + c_OCC_W'(r_tag[k].valid);
    end
  end

  // Every issued read reserves a FIFO slot up front, so a returning word
  // always finds room regardless of downstream backpressure.
  assign w_occupancy = c_OCC_W'(w_fifo_count) + w_inflight;
  assign w_credit    = (w_occupancy < c_OCC_W'(FIFO_DEPTH));

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_line_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs_rise && w_rd_en_s) w_state_next = ST_READ;
      end
      ST_READ: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_addr == c_LAST_ADDR) w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_inflight == '0) begin
          w_line_done  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_addr        <= '0;
      r_sof_pending <= 1'b0;
      r_overrun     <= 1'b0;
      r_line_cnt    <= '0;
    end else begin
      if (w_issue) begin
        r_addr <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
      end

      // A new frame arms SOF for the next line start; an in-progress line is
      // left alone and finishes normally.
      if (w_vs_rise) begin
        r_sof_pending <= 1'b1;
      end else if (w_issue && (r_addr == '0) && r_sof_pending) begin
        r_sof_pending <= 1'b0;
      end

      if (w_hs_rise && (r_state != ST_IDLE)) r_overrun <= 1'b1;

      if (w_vs_rise) begin
        r_line_cnt <= '0;
      end else if (w_line_done && (r_line_cnt != '1)) begin
        r_line_cnt <= r_line_cnt + c_LINE_CNT_W'(1);
      end
    end
  end

  // Tag pipeline mirrors the buffer read latency so the tag exits exactly
  // when the matching word is valid on DATA_IN.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int k = 0; k < READ_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].valid <= w_issue;
      r_tag[0].sof   <= w_issue && (r_addr == '0) && r_sof_pending;
      r_tag[0].eol   <= w_issue && (r_addr == c_LAST_ADDR);
      for (int k = 1; k < READ_LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_push = r_tag[READ_LATENCY-1].valid;
  assign w_pop  = !w_fifo_empty && M_AXIS.TREADY;

  axis_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESETN),
    .i_push  (w_push),
    .i_tdata (DATA_IN),
    .i_tuser (r_tag[READ_LATENCY-1].sof),
    .i_tlast (r_tag[READ_LATENCY-1].eol),
    .i_pop   (w_pop),
    .o_tdata (w_head_tdata),
    .o_tuser (w_head_tuser),
    .o_tlast (w_head_tlast),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign ADDRB         = r_addr;
  assign OVERRUN       = r_overrun;
  assign LINE_CNT      = r_line_cnt;
  assign M_AXIS.TDATA  = w_head_tdata;
  assign M_AXIS.TUSER  = w_head_tuser;
  assign M_AXIS.TLAST  = w_head_tlast;
  assign M_AXIS.TVALID = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_yuv_line_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_yuv_line_streamer                                       |
// | Description : Self-checking bench for yuv_line_streamer. A line-buffer   |
// |               model returns seed-dependent words; expected beats are     |
// |               built from the frame/line rules and compared beat by beat. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_yuv_line_streamer;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LW  = 320;
  localparam int LAT = 2;
  localparam int FD  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync;
  logic          hsync;
  logic          rd_en;
  logic [AW-1:0] addrb;
  logic [DW-1:0] data_in;
  logic          overrun;
  logic [15:0]   line_cnt;

  yuv_line_streamer_if #(.DATA_WIDTH(DW)) axis_if ();

  yuv_line_streamer #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .LINE_WORDS   (LW),
    .READ_LATENCY (LAT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .CLK      (clk),
    .RESETN   (rst_n),
    .VSYNC    (vsync),
    .HSYNC    (hsync),
    .RD_EN    (rd_en),
    .ADDRB    (addrb),
    .DATA_IN  (data_in),
    .M_AXIS   (axis_if),
    .OVERRUN  (overrun),
    .LINE_CNT (line_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ------------------------------------------------ line-buffer model
  logic [31:0] seed = 32'h1234_5678;

  function automatic logic [DW-1:0] pat(input logic [31:0] s, input logic [AW-1:0] a);
    logic [31:0] ax;
    ax = {{(32-AW){1'b0}}, a};
    return s ^ (ax * 32'h9E37_79B1) ^ (ax << 20);
  endfunction

  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= pat(seed, addrb);
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign data_in = rd_pipe[LAT-1];

  // ------------------------------------------------ monitor (records only)
  logic [DW+1:0] obs_q[$];
  int            obs_cyc[$];
  int            addr1_q[$];
  int            vrise_q[$];
  int            stab_err  = 0;
  int            stall_cnt = 0;

  initial begin
    logic          prev_hold;
    logic          prev_tvalid;
    logic [DW+1:0] prev_beat;
    logic [DW+1:0] cur;
    logic [AW-1:0] prev_addrb;
    prev_hold   = 1'b0;
    prev_tvalid = 1'b0;
    prev_beat   = '0;
    prev_addrb  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_hold   = 1'b0;
        prev_tvalid = 1'b0;
        prev_addrb  = '0;
      end else begin
        cur = {axis_if.TUSER, axis_if.TLAST, axis_if.TDATA};
        if (prev_hold && (!axis_if.TVALID || cur !== prev_beat)) stab_err++;
        if (axis_if.TVALID && axis_if.TREADY) begin
          obs_q.push_back(cur);
          obs_cyc.push_back(cyc);
        end
        if (axis_if.TVALID && !prev_tvalid) vrise_q.push_back(cyc);
        if (addrb == AW'(1) && prev_addrb == '0) addr1_q.push_back(cyc);
        if (addrb != '0 && addrb == prev_addrb) stall_cnt++;
        prev_hold   = axis_if.TVALID && !axis_if.TREADY;
        prev_beat   = cur;
        prev_tvalid = axis_if.TVALID;
        prev_addrb  = addrb;
      end
    end
  end

  // ------------------------------------------------ reference model state
  logic [DW+1:0] exp_q[$];
  logic          m_sof   = 1'b0;
  int            m_lines = 0;

  // ------------------------------------------------ stimulus helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    tick(4);
    m_sof   = 1'b1;
    m_lines = 0;
  endtask

  task automatic pulse_hsync();
    hsync = 1'b1;
    tick(4);
    hsync = 1'b0;
    tick(4);
  endtask

  // Builds the expected line from the frame rules, then triggers it.
  task automatic start_line();
    seed = $urandom;
    exp_q.delete();
    for (int i = 0; i < LW; i++) begin
      exp_q.push_back({m_sof && (i == 0), (i == LW-1), pat(seed, AW'(i))});
    end
    m_sof = 1'b0;
    pulse_hsync();
  endtask

  task automatic wait_beats(input int base, input bit rand_ready, input int limit);
    int t;
    t = 0;
    while (obs_q.size() < base + LW && t < limit) begin
      if (rand_ready) axis_if.TREADY = ($urandom_range(0, 99) < 30);
      tick(1);
      t++;
    end
    axis_if.TREADY = 1'b1;
    if (obs_q.size() < base + LW) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", obs_q.size() - base, LW);
    end
    if (m_lines < 16'hFFFF) m_lines++;
    tick(24);
  endtask

  task automatic wait_addr(input logic [AW-1:0] target);
    int t;
    t = 0;
    while (addrb !== target && t < 3000) begin
      tick(1);
      t++;
    end
    if (addrb !== target) begin
      checks++;
      errors++;
      $display("FAIL addr_timeout: ADDRB=%0d, required %0d", addrb, target);
    end
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    tick(5);
    checks++;
    if ({addrb, axis_if.TVALID, axis_if.TUSER, axis_if.TLAST, axis_if.TDATA, overrun, line_cnt}
        !== '0) begin
      errors++;
      $display("FAIL reset_values: addrb=%0d tvalid=%b tuser=%b tlast=%b tdata=%h ovr=%b cnt=%0d, required all 0",
               addrb, axis_if.TVALID, axis_if.TUSER, axis_if.TLAST, axis_if.TDATA, overrun, line_cnt);
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_first_line();
    int base, a0, v0;
    pulse_vsync();
    base = obs_q.size();
    a0   = addr1_q.size();
    v0   = vrise_q.size();
    start_line();
    wait_beats(base, 1'b0, 2000);
    checks++;
    if (obs_q.size() !== base + LW) begin
      errors++;
      $display("FAIL first_line_count: got %0d beats, required %0d", obs_q.size() - base, LW);
    end
    for (int i = 0; i < LW && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL first_line beat %0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    if (obs_q.size() >= base + LW) begin
      checks++;
      if (obs_cyc[base+LW-1] - obs_cyc[base] !== LW - 1) begin
        errors++;
        $display("FAIL throughput: span %0d cycles, required %0d", obs_cyc[base+LW-1] - obs_cyc[base], LW - 1);
      end
    end
    checks++;
    if (addr1_q.size() <= a0 || vrise_q.size() <= v0) begin
      errors++;
      $display("FAIL first_beat_latency: events missing, addr1=%0d vrise=%0d", addr1_q.size() - a0, vrise_q.size() - v0);
    end else if (vrise_q[v0] - addr1_q[a0] !== LAT) begin
      errors++;
      $display("FAIL first_beat_latency: got %0d, required %0d", vrise_q[v0] - addr1_q[a0], LAT);
    end
    checks++;
    if (line_cnt !== 16'(m_lines)) begin
      errors++;
      $display("FAIL first_line_cnt: got %0d, required %0d", line_cnt, m_lines);
    end
    checks++;
    if (addrb !== '0) begin
      errors++;
      $display("FAIL idle_addr: got %0d, required 0", addrb);
    end
  endtask

  task automatic test_second_line();
    int base;
    base = obs_q.size();
    start_line();
    wait_beats(base, 1'b0, 2000);
    checks++;
    if (obs_q.size() !== base + LW) begin
      errors++;
      $display("FAIL second_line_count: got %0d beats, required %0d", obs_q.size() - base, LW);
    end
    for (int i = 0; i < LW && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL second_line beat %0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (line_cnt !== 16'(m_lines)) begin
      errors++;
      $display("FAIL second_line_cnt: got %0d, required %0d", line_cnt, m_lines);
    end
  endtask

  task automatic test_ignored_hsync();
    int base;
    rd_en = 1'b0;
    tick(4);
    base = obs_q.size();
    pulse_hsync();
    tick(40);
    checks++;
    if (obs_q.size() !== base) begin
      errors++;
      $display("FAIL ignored_hsync: got %0d beats, required 0", obs_q.size() - base);
    end
    checks++;
    if (line_cnt !== 16'(m_lines)) begin
      errors++;
      $display("FAIL ignored_hsync_cnt: got %0d, required %0d", line_cnt, m_lines);
    end
    rd_en = 1'b1;
    tick(4);
  endtask

  task automatic test_backpressure();
    int base, st0, sc0;
    base = obs_q.size();
    st0  = stab_err;
    sc0  = stall_cnt;
    start_line();
    wait_beats(base, 1'b1, 20000);
    checks++;
    if (obs_q.size() !== base + LW) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, required %0d", obs_q.size() - base, LW);
    end
    for (int i = 0; i < LW && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp beat %0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (stab_err - st0 !== 0) begin
      errors++;
      $display("FAIL axis_stability: got %0d violations, required 0", stab_err - st0);
    end
    checks++;
    if (stall_cnt - sc0 <= 0) begin
      errors++;
      $display("FAIL addr_stall: got %0d stall cycles, required > 0", stall_cnt - sc0);
    end
    checks++;
    if (line_cnt !== 16'(m_lines)) begin
      errors++;
      $display("FAIL bp_line_cnt: got %0d, required %0d", line_cnt, m_lines);
    end
  endtask

  task automatic test_overrun();
    int base;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b, required 0", overrun);
    end
    base = obs_q.size();
    start_line();
    wait_addr(AW'(50));
    pulse_hsync();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    wait_beats(base, 1'b0, 2000);
    tick(40);
    checks++;
    if (obs_q.size() !== base + LW) begin
      errors++;
      $display("FAIL overrun_count: got %0d beats, required %0d", obs_q.size() - base, LW);
    end
    for (int i = 0; i < LW && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL overrun beat %0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (overrun !== 1'b1 || line_cnt !== 16'(m_lines)) begin
      errors++;
      $display("FAIL overrun_after: ovr=%b cnt=%0d, required ovr=1 cnt=%0d", overrun, line_cnt, m_lines);
    end
  endtask

  task automatic test_vsync_mid_line();
    int base;
    base = obs_q.size();
    start_line();
    wait_addr(AW'(200));
    pulse_vsync();
    checks++;
    if (line_cnt !== 16'd0) begin
      errors++;
      $display("FAIL vsync_clear_cnt: got %0d, required 0", line_cnt);
    end
    wait_beats(base, 1'b0, 2000);
    checks++;
    if (obs_q.size() !== base + LW) begin
      errors++;
      $display("FAIL vsync_line_count: got %0d beats, required %0d", obs_q.size() - base, LW);
    end
    for (int i = 0; i < LW && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL vsync_line beat %0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (line_cnt !== 16'd1) begin
      errors++;
      $display("FAIL vsync_line_cnt: got %0d, required 1", line_cnt);
    end
    base = obs_q.size();
    start_line();
    wait_beats(base, 1'b0, 2000);
    for (int i = 0; i < LW && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL new_frame beat %0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (line_cnt !== 16'd2) begin
      errors++;
      $display("FAIL new_frame_cnt: got %0d, required 2", line_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    int base;
    start_line();
    wait_addr(AW'(100));
    rst_n = 1'b0;
    #1;
    checks++;
    if ({addrb, axis_if.TVALID, axis_if.TUSER, axis_if.TLAST, axis_if.TDATA, overrun, line_cnt}
        !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: addrb=%0d tvalid=%b tuser=%b tlast=%b tdata=%h ovr=%b cnt=%0d, required all 0",
               addrb, axis_if.TVALID, axis_if.TUSER, axis_if.TLAST, axis_if.TDATA, overrun, line_cnt);
    end
    tick(3);
    rst_n   = 1'b1;
    m_sof   = 1'b0;
    m_lines = 0;
    tick(6);
    checks++;
    if (addrb !== '0 || axis_if.TVALID !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: addrb=%0d tvalid=%b, required 0 0", addrb, axis_if.TVALID);
    end
    base = obs_q.size();
    start_line();
    wait_beats(base, 1'b0, 2000);
    checks++;
    if (obs_q.size() !== base + LW) begin
      errors++;
      $display("FAIL post_reset_count: got %0d beats, required %0d", obs_q.size() - base, LW);
    end
    for (int i = 0; i < LW && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL post_reset beat %0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (line_cnt !== 16'(m_lines) || overrun !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_status: cnt=%0d ovr=%b, required cnt=%0d ovr=0", line_cnt, overrun, m_lines);
    end
  endtask

  // ------------------------------------------------ sequence
  initial begin
    rst_n          = 1'b0;
    vsync          = 1'b0;
    hsync          = 1'b0;
    rd_en          = 1'b1;
    axis_if.TREADY = 1'b1;
    test_reset();
    test_first_line();
    test_second_line();
    test_ignored_hsync();
    test_backpressure();
    test_overrun();
    test_vsync_mid_line();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
